// File: rtl/datapath_pkg.sv
// Shared datapath types: register index width and the scoreboard FSM state.
package datapath_pkg;
  localparam int NREGS = 32;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic {
    NORMAL = 1'b0,
    SPEC   = 1'b1
  } sb_state_t;
endpackage

// File: rtl/scoreboard_hazard.sv
// Combinational hazard detection for one issuing instruction against the pending bitmap.
module scoreboard_hazard
  import datapath_pkg::*;
#(
  parameter int NREGS = datapath_pkg::NREGS,
  parameter int REG_W = datapath_pkg::REG_W
) (
  input  logic [NREGS-1:0] pending,
  input  logic [NREGS-1:0] clr_hit,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             writes_rd,
  output logic             rs1_haz,
  output logic             rs2_haz,
  output logic             waw_haz
);
  // A same-cycle writeback to the register removes the hazard (bypass).
  assign rs1_haz = uses_rs1  && (rs1 != '0) && pending[rs1] && !clr_hit[rs1];
  assign rs2_haz = uses_rs2  && (rs2 != '0) && pending[rs2] && !clr_hit[rs2];
  assign waw_haz = writes_rd && (rd  != '0) && pending[rd]  && !clr_hit[rd];
endmodule

// File: rtl/scalar_scoreboard.sv
// Scalar register scoreboard: tracks in-flight destinations, gates issue on RAW/WAW
// hazards and squashes destinations issued under an unresolved branch.
module scalar_scoreboard
  import datapath_pkg::*;
#(
  parameter int NREGS = datapath_pkg::NREGS,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_uses_rs1,
  input  logic             issue_uses_rs2,
  input  logic             issue_writes_rd,
  input  logic             issue_is_branch,
  output logic             issue_ready,
  output logic             issue_spec,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             branch_correct,
  input  logic             branch_mispredict,
  output logic [NREGS-1:0] pending,
  output logic [NREGS-1:0] spec_mask,
  output logic             sb_state
);
  // Handshake: an instruction fires on a cycle where issue_valid && issue_ready;
  // issue_ready never depends on issue_valid.

  sb_state_t        state, state_nxt;
  logic [NREGS-1:0] clr_hit, set_vec, pending_nxt, spec_nxt;
  logic             rs1_haz, rs2_haz, waw_haz, fire;
  logic             resolve_ok, resolve_bad;

  scoreboard_hazard #(.NREGS(NREGS), .REG_W(REG_W)) u_hazard (
    .pending   (pending),
    .clr_hit   (clr_hit),
    .rs1       (issue_rs1),
    .rs2       (issue_rs2),
    .rd        (issue_rd),
    .uses_rs1  (issue_uses_rs1),
    .uses_rs2  (issue_uses_rs2),
    .writes_rd (issue_writes_rd),
    .rs1_haz   (rs1_haz),
    .rs2_haz   (rs2_haz),
    .waw_haz   (waw_haz)
  );

  assign issue_ready = !(rs1_haz || rs2_haz || waw_haz)
                    && !(issue_is_branch && state == SPEC)
                    && !branch_mispredict;
  assign issue_spec  = (state == SPEC);
  assign sb_state    = state;
  assign fire        = issue_valid && issue_ready;

  // Mispredict wins if both strobes are seen together.
  assign resolve_bad = (state == SPEC) && branch_mispredict;
  assign resolve_ok  = (state == SPEC) && branch_correct && !branch_mispredict;

  always_comb begin
    clr_hit = '0;
    set_vec = '0;
    if (wb_en && wb_rd != '0)
      clr_hit[wb_rd] = 1'b1;
    if (fire && issue_writes_rd && issue_rd != '0)
      set_vec[issue_rd] = 1'b1;
  end

  always_comb begin
    pending_nxt = pending & ~clr_hit;
    spec_nxt    = spec_mask & ~clr_hit;
    if (resolve_bad)
      pending_nxt = pending_nxt & ~spec_mask;
    if (resolve_bad || resolve_ok)
      spec_nxt = '0;
    // A fire setting the register it also writes back keeps it pending.
    pending_nxt = pending_nxt | set_vec;
    if (state == SPEC && !branch_correct)
      spec_nxt = spec_nxt | set_vec;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (fire && issue_is_branch) state_nxt = SPEC;
      SPEC:    if (branch_correct || branch_mispredict) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= NORMAL;
      pending   <= '0;
      spec_mask <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      spec_mask <= spec_nxt;
    end
  end
endmodule

// File: doc/scalar_scoreboard.md
# scalar_scoreboard

Tracks in-flight scalar destination registers between issue and writeback, and gates issue on RAW/WAW hazards. It sits downstream of the writeback stage, consuming its register-write strobe to retire pending destinations. It is also fed by branch resolution to commit or squash speculatively issued destinations. Only one unresolved branch may be outstanding at a time.

## Interface
Parameters:
- NREGS, 32, number of scalar architectural registers (register 0 hardwired zero)
- REG_W, 5, register index width, $clog2(NREGS)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_rs1, issue_rs2, issue_rd  in  REG_W each  source/destination indices
- issue_uses_rs1, issue_uses_rs2, issue_writes_rd  in  1 each  operand/destination valid flags
- issue_is_branch  in  1  instruction is a conditional branch
- issue_ready  out  1  no hazard; the instruction fires when issue_valid && issue_ready
- issue_spec  out  1  fired instruction is speculative (state == SPEC)
- wb_en  in  1  writeback stage writes a register this cycle
- wb_rd  in  REG_W  register written
- branch_correct  in  1  outstanding branch resolved, predicted correctly
- branch_mispredict  in  1  outstanding branch resolved, mispredicted
- pending  out  NREGS  registered bitmap of in-flight destinations
- spec_mask  out  NREGS  registered bitmap of pending destinations issued under speculation

## Operation
- FSM states: NORMAL, SPEC.
  - NORMAL -> SPEC when a branch fires.
  - SPEC -> NORMAL on branch_correct or branch_mispredict.
  - Resolution strobes in NORMAL are ignored.
- A clear hit means wb_en && wb_rd == r.
- A source operand hazards when it is used, is nonzero, pending[r] = 1, and there is no clear hit on r this cycle (same-cycle writeback bypass).
- A destination (WAW) hazards when issue_writes_rd is set, rd is nonzero, and pending[rd] = 1 with no clear hit. This guarantees one producer per register.
- issue_ready = 0 in any of these cases:
  - any source hazard
  - a destination (WAW) hazard
  - issue_is_branch in SPEC
  - branch_mispredict asserted this cycle
- On fire with issue_writes_rd && rd != 0: set pending[rd], and set spec_mask[rd] iff state == SPEC and branch_correct is not asserted this cycle.
- Clear hit: clear pending[wb_rd] and spec_mask[wb_rd]. If a fire sets the same register in the same cycle, the set wins.
- branch_correct (in SPEC): spec_mask <= 0; pending is unchanged.
- branch_mispredict (in SPEC): pending <= pending & ~spec_mask; spec_mask <= 0.
  - Squashed ops are killed in the FUs and never raise wb_en.
  - A non-speculative clear hit in the same cycle still applies.
- Bit 0 of pending and spec_mask is constant 0; wb_rd == 0 is ignored.

## Timing
- issue_ready and issue_spec are combinational from inputs and the current state.
- pending, spec_mask and state update on the CLK rising edge; effects are visible one cycle after fire or writeback.
- Fire-to-dependent-issue: a dependent may fire in the same cycle as the producer's wb_en.
- Reset (async, nRST low): pending = 0, spec_mask = 0, state = NORMAL, so issue_ready is governed by inputs only.
- Reset asserted mid-speculation discards all tracking immediately.
- branch_correct and branch_mispredict are mutually exclusive. If both are asserted, mispredict takes priority; this is an assertion failure in verification.

## Structure
- Add sb_state_t (NORMAL, SPEC) to datapath_pkg; reuse regbits_t for register indices.
- One sub-module, scoreboard_hazard: purely combinational. It takes pending, the clear-hit vector and the issue fields, and produces the hazard flags. The scoreboard instantiates it; it is unit-testable separately.

## Test plan
- Reset, then fire rd=5 (no sources) -> pending[5] = 1 next cycle. Dependent with rs1=5 gets issue_ready = 0 until wb_en with wb_rd = 5, when issue_ready = 1 in that same cycle.
- Fire rd=0 and wb_rd=0 -> pending stays 0; a rs1=0 consumer is never stalled.
- Pending[7] set, then issue writes rd=7 -> WAW stall. In the same cycle, wb_rd=7 with a new fire to rd=7 -> pending[7] remains 1.
- Branch fires -> SPEC; fire rd=3 -> spec_mask[3] = 1; second branch -> issue_ready = 0. Then branch_correct -> spec_mask = 0, pending[3] = 1, state NORMAL.
- In SPEC, pending[3] is speculative and pending[4] is non-speculative. branch_mispredict -> pending[3] = 0 and pending[4] = 1; issue_ready = 0 during the mispredict cycle.
- Pending = 0x0000_0030 in SPEC; drop nRST asynchronously mid-cycle -> all outputs clear before the next edge; state NORMAL.
